// File: rtl/jtdsp16_pkg.sv
// Shared DSP16 definitions.
// Provides the do-cache sequencer state encoding and the default loop-body depth.
package jtdsp16_pkg;

  typedef enum logic [1:0] {
    DOC_IDLE   = 2'd0,
    DOC_FILL   = 2'd1,
    DOC_REPLAY = 2'd2
  } doc_state_t;

  localparam int DSP16_CACHE_DEPTH = 15;

endpackage

// File: rtl/jtdsp16_docache_if.sv
// Decoder-side bus of the do/redo loop cache.
// master: decoder/ROM side, drives the loop requests, the fetch strobe and the ROM word.
// slave : the cache, returns the replay word, the mux select and the status flags.
interface jtdsp16_docache_if #(
  parameter int DW = 16,
  parameter int AW = 4,
  parameter int KW = 7
);
  logic          cen;
  logic          do_start;
  logic          redo_start;
  logic [AW-1:0] do_ni;
  logic [KW-1:0] do_k;
  logic          fetch_en;
  logic          abort;
  logic [DW-1:0] rom_dout;
  logic [DW-1:0] cache_dout;
  logic          cache_sel;
  logic          pc_halt;
  logic          busy;
  logic          loop_last;
  logic          cache_err;
  logic          cache_valid;

  modport master (
    output cen, do_start, redo_start, do_ni, do_k, fetch_en, abort, rom_dout,
    input  cache_dout, cache_sel, pc_halt, busy, loop_last, cache_err, cache_valid
  );

  modport slave (
    input  cen, do_start, redo_start, do_ni, do_k, fetch_en, abort, rom_dout,
    output cache_dout, cache_sel, pc_halt, busy, loop_last, cache_err, cache_valid
  );
endinterface

// File: rtl/jtdsp16_docache_mem.sv
// Loop-body storage: DEPTH x DW register file.
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata asynchronous read.
// Contents are not reset.
module jtdsp16_docache_mem
  import jtdsp16_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = DSP16_CACHE_DEPTH,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jtdsp16_docache.sv
// DSP16 do/redo loop cache and sequencer.
// Captures the loop body from ROM on the first pass, then replays it from local
// storage for the remaining passes while freezing the PC.
// Ports: clk, rst (synchronous, active low), bus (jtdsp16_docache_if.slave).
//
// state      | meaning
// DOC_IDLE   | no loop active, waiting for do/redo
// DOC_FILL   | first pass, body fetched from ROM and written to storage
// DOC_REPLAY | later passes, body read from storage, PC frozen
module jtdsp16_docache
  import jtdsp16_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = DSP16_CACHE_DEPTH,
  parameter int AW    = 4,
  parameter int KW    = 7
) (
  input logic               clk,
  input logic               rst,
  jtdsp16_docache_if.slave  bus
);

  localparam logic [AW-1:0] NI_ONE = AW'(1);
  localparam logic [AW-1:0] NI_MAX = AW'(DEPTH);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  doc_state_t    state;
  logic [AW-1:0] wr_ptr, rd_ptr, ni_reg;
  logic [KW-1:0] iter;
  logic          valid_q, err_q, sel_q;
  logic          do_ok, redo_ok, wr_last, rd_last, last_iter, mem_we;

  assign do_ok     = (bus.do_ni != '0) && (bus.do_ni <= NI_MAX) && (bus.do_k != '0);
  assign redo_ok   = valid_q && (bus.do_k != '0);
  assign wr_last   = (wr_ptr == (ni_reg - NI_ONE));
  assign rd_last   = (rd_ptr == (ni_reg - NI_ONE));
  assign last_iter = (iter == K_ONE);
  // Abort beats the fill write so a flushed loop leaves no half-written word.
  assign mem_we    = rst && bus.cen && !bus.abort && bus.fetch_en && (state == DOC_FILL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= DOC_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ni_reg  <= '0;
      iter    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else if (bus.cen) begin
      err_q <= 1'b0;
      if (bus.abort) begin
        state <= DOC_IDLE;
        sel_q <= 1'b0;
        // A partial body is useless; a completed body survives a replay abort.
        if (state == DOC_FILL) valid_q <= 1'b0;
      end else begin
        case (state)
          DOC_IDLE: begin
            // do wins over a simultaneous redo, which is dropped silently.
            if (bus.do_start) begin
              if (do_ok) begin
                ni_reg  <= bus.do_ni;
                iter    <= bus.do_k;
                wr_ptr  <= '0;
                valid_q <= 1'b0;
                state   <= DOC_FILL;
              end else begin
                err_q <= 1'b1;
              end
            end else if (bus.redo_start) begin
              if (redo_ok) begin
                iter   <= bus.do_k;
                rd_ptr <= '0;
                sel_q  <= 1'b1;
                state  <= DOC_REPLAY;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          DOC_FILL: begin
            if (bus.do_start || bus.redo_start) err_q <= 1'b1;
            if (bus.fetch_en) begin
              wr_ptr <= wr_ptr + NI_ONE;
              if (wr_last) begin
                valid_q <= 1'b1;
                if (last_iter) begin
                  state <= DOC_IDLE;
                end else begin
                  // Select goes up with the last ROM word so the next fetch has no bubble.
                  iter   <= iter - K_ONE;
                  rd_ptr <= '0;
                  sel_q  <= 1'b1;
                  state  <= DOC_REPLAY;
                end
              end
            end
          end
          DOC_REPLAY: begin
            if (bus.do_start || bus.redo_start) err_q <= 1'b1;
            if (bus.fetch_en) begin
              if (rd_last) begin
                rd_ptr <= '0;
                if (last_iter) begin
                  sel_q <= 1'b0;
                  state <= DOC_IDLE;
                end else begin
                  iter <= iter - K_ONE;
                end
              end else begin
                rd_ptr <= rd_ptr + NI_ONE;
              end
            end
          end
          default: begin
            sel_q <= 1'b0;
            state <= DOC_IDLE;
          end
        endcase
      end
    end
  end

  jtdsp16_docache_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (bus.rom_dout),
    .raddr (rd_ptr),
    .rdata (bus.cache_dout)
  );

  assign bus.cache_sel   = sel_q;
  assign bus.pc_halt     = sel_q;
  assign bus.busy        = (state != DOC_IDLE);
  assign bus.loop_last   = (state == DOC_REPLAY) && last_iter;
  assign bus.cache_err   = err_q;
  assign bus.cache_valid = valid_q;

endmodule

// File: doc/jtdsp16_docache.md
# jtdsp16_docache

Parametrised instruction cache and loop sequencer for the DSP16 `do K { NI }` and `redo K` instructions. It sits between program ROM and the instruction decoder (`jtdsp16_ctrl`). During the first pass of a loop it captures the body straight from ROM. For the remaining K−1 passes it replays the body from local storage and halts the XAAU program counter. It drives the decoder's instruction mux through `cache_sel` and `cache_dout`, replacing the fixed 15-entry behaviour with configurable depth, data width and repeat-count width.

## Interface
Parameters:
- DW, 16, instruction word width
- DEPTH, 15, maximum loop body length in instructions (≥2)
- AW, 4, body-length and pointer width; must satisfy 2^AW > DEPTH
- KW, 7, repeat-count width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on clk)
- cen  in  1  clock enable; all state advances only when cen=1
- do_start  in  1  decoder found `do`; qualified by cen
- redo_start  in  1  decoder found `redo`; qualified by cen
- do_ni  in  AW  body length NI (do only)
- do_k  in  KW  repeat count K (do and redo)
- fetch_en  in  1  one instruction is consumed this cen cycle
- abort  in  1  flush loop (IRQ entry, debugger); qualified by cen
- rom_dout  in  DW  ROM instruction word
- cache_dout  out  DW  replayed instruction, mem[rd_ptr]
- cache_sel  out  1  decoder takes cache_dout instead of rom_dout
- pc_halt  out  1  freeze PC increment
- busy  out  1  state ≠ IDLE
- loop_last  out  1  REPLAY state and final iteration
- cache_err  out  1  one-cen pulse: illegal do/redo was rejected
- cache_valid  out  1  stored body usable by redo

## Operation
- States: IDLE, FILL, REPLAY.
- Registers: mem[0..DEPTH−1], wr_ptr, rd_ptr, ni_reg (AW bits), iter (KW bits), cache_valid.

IDLE:
- `do_start` with 1≤do_ni≤DEPTH and do_k≥1:
  - ni_reg←do_ni, iter←do_k, wr_ptr←0, cache_valid←0.
  - Next state FILL.
- `do_start` otherwise: cache_err pulse, stay IDLE.
- `redo_start` with cache_valid=1 and do_k≥1:
  - iter←do_k, rd_ptr←0.
  - Next state REPLAY; ni_reg is kept.
- `redo_start` with cache_valid=0 or do_k=0: cache_err pulse, stay IDLE.
- do_start and redo_start together: do_start wins and the redo is dropped silently.

FILL (body executes from ROM, PC runs normally):
- On each fetch_en: mem[wr_ptr]←rom_dout, wr_ptr++.
- On the fetch where wr_ptr=ni_reg−1:
  - cache_valid←1.
  - If iter=1, go to IDLE.
  - Otherwise iter←iter−1, rd_ptr←0, go to REPLAY.

REPLAY:
- cache_sel=1 and pc_halt=1.
- On each fetch_en: rd_ptr++.
- When rd_ptr=ni_reg−1 on a fetch: rd_ptr←0 (wrap).
  - If iter=1, go to IDLE.
  - Otherwise iter←iter−1.
- loop_last = (state=REPLAY) & (iter=1).

Boundary rules:
- do_start or redo_start while busy: ignored, cache_err pulse. Loops do not nest.
- abort:
  - Takes priority over all other events; next state is IDLE.
  - If abort hits during FILL, cache_valid←0.
  - If abort hits during REPLAY, cache_valid stays 1.
- fetch_en=0 holds every pointer and counter.
- NI=1 is legal: REPLAY wraps on every fetch.

Reset values:
- state IDLE; cache_sel, pc_halt, busy, loop_last, cache_err, cache_valid all 0.
- wr_ptr, rd_ptr, iter, ni_reg = 0.
- cache_dout = mem[0]. mem contents are not reset.

## Timing
- do_start is sampled on a cen edge. The first body instruction is the next fetch, and it is written on that same edge.
- cache_sel and pc_halt are registered. They go high on the edge that captures the last FILL word, so the very next fetch comes from the cache. No bubble is allowed.
- cache_dout is an asynchronous read of mem[rd_ptr], valid in the same cycle as cache_sel.
- cache_sel and pc_halt drop on the edge that consumes the last replayed word. The next fetch comes from ROM at the post-loop PC.
- cache_err is high for exactly one cen period.
- Loop cost: NI×K fetches in total, of which NI come from ROM.

## Structure
- Shared package `jtdsp16_pkg`:
  - state encoding constants `DOC_IDLE`, `DOC_FILL`, `DOC_REPLAY`;
  - default `DSP16_CACHE_DEPTH` = 15.
- One sub-module, `jtdsp16_docache_mem`: a DEPTH×DW register file with one synchronous write port and one asynchronous read port. The sequencer FSM stays in the top module.

## Test plan
- do NI=3 K=2, ROM words A,B,C on consecutive fetches → decoder sees A,B,C (ROM), then A,B,C (cache). pc_halt is high for exactly 3 fetches. cache_valid=1 at end.
- do NI=2 K=1 → two ROM fetches, no REPLAY, cache_sel never asserts, cache_valid=1.
- After the first test, redo K=3 → 9 cache fetches A,B,C×3. loop_last is high only for the final 3. busy drops after the 9th fetch.
- Illegal cases each give one cache_err pulse with state unchanged:
  - do NI=0;
  - do NI=DEPTH+1;
  - redo after reset;
  - do_start while in REPLAY.
- NI=DEPTH=15, K=4, with fetch_en toggled randomly → 60 fetches total, correct wrap, no pointer advance on fetch_en=0 cycles.
- Two reset/abort cases:
  - abort in FILL after 1 of 3 words → IDLE, cache_valid=0, and a following redo raises cache_err;
  - rst=0 mid-REPLAY → all outputs at their reset values on the next clk, regardless of cen.
